turn_sequencer: RTL

TURN_SEQUENCER -- requirements
Module: turn_sequencer

---
 rtl/turn_sequencer_pkg.sv | 42 ++++
 rtl/turn_sequencer_pwm_gen.sv | 62 ++++++
 rtl/turn_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the turn sequencer: DIR code fields, controller
// states and the nominal motor duty levels (scaled for an 8-bit PWM counter).
package turn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PIVOT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // DIR = {turn[1:0], grade[1:0]}
    localparam logic [1:0] TURN_NONE    = 2'b00;
    localparam logic [1:0] TURN_LEFT    = 2'b01;
    localparam logic [1:0] TURN_RIGHT   = 2'b10;
    localparam logic [1:0] TURN_BOTH    = 2'b11;

    localparam logic [1:0] GRADE_NONE   = 2'b00;
    localparam logic [1:0] GRADE_VEER   = 2'b01;
    localparam logic [1:0] GRADE_HARD   = 2'b10;
    localparam logic [1:0] GRADE_NINETY = 2'b11;

    localparam logic [3:0] DIR_PROCEED  = 4'b0000;
    localparam logic [3:0] DIR_STOP     = 4'b1111;

    localparam int DUTY_FULL  = 200;
    localparam int DUTY_VEER  = 120;
    localparam int DUTY_HARD  = 40;
    localparam int DUTY_PIVOT = 160;

    // A grade without a turn side, or both sides with anything but the
    // ninety grade (which is the stop code), has no meaning.
    function automatic logic dir_defined(input logic [3:0] dir);
        logic no_side_graded;
        logic both_not_stop;
        no_side_graded = (dir[3:2] == TURN_NONE) && (dir[1:0] != GRADE_NONE);
        both_not_stop  = (dir[3:2] == TURN_BOTH) && (dir[1:0] != GRADE_NINETY);
        dir_defined    = !(no_side_graded || both_not_stop);
    endfunction

endpackage

// File: rtl/turn_sequencer_pwm_gen.sv
// One motor PWM channel: free-running counter, duty/reverse loaded only at
// the period wrap, compare output. With TURN_SEQ_RAMP_EN defined the applied
// duty climbs toward the target by at most RAMP_STEP per period.
module pwm_gen
    import turn_seq_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] target,
    input  logic                rev_target,
    output logic                pwm,
    output logic                rev
);

`ifdef TURN_SEQ_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(RAMP_STEP);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic                wrap;

    // Rising targets are approached in bounded steps; falling ones are taken at once.
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] stepped;
        stepped = {1'b0, cur} + STEP_EXT;
        if ((tgt <= cur) || (stepped >= {1'b0, tgt}))
            ramp_toward = tgt;
        else
            ramp_toward = stepped[PWM_BITS-1:0];
    endfunction

    assign wrap      = (cnt == {PWM_BITS{1'b1}});
    assign duty_next = RAMP_EN ? ramp_toward(duty, target) : target;

    // Counter runs freely; duty and reverse select change only as it wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            duty <= '0;
            rev  <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (wrap) begin
                duty <= duty_next;
                rev  <= rev_target;
            end
        end
    end

    assign pwm = (cnt < duty);

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: decodes the DIR command into per-motor duty targets,
// sequences 90-degree pivots (pivot then settle), and halts on stop or
// malformed codes. Optional feature macro: TURN_SEQ_RAMP_EN (duty ramping
// inside pwm_gen).
module turn_sequencer
    import turn_seq_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int PIVOT_TICKS  = 25_000_000,
    parameter int SETTLE_TICKS = 12_500_000,
    parameter int RAMP_STEP    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] DIR,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_rev,
    output logic       right_rev,
    output logic       busy,
    output logic       halted
);

    localparam int TICK_MAX = (PIVOT_TICKS > SETTLE_TICKS) ? PIVOT_TICKS : SETTLE_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [PWM_BITS-1:0] D_FULL  = PWM_BITS'(DUTY_FULL);
    localparam logic [PWM_BITS-1:0] D_VEER  = PWM_BITS'(DUTY_VEER);
    localparam logic [PWM_BITS-1:0] D_HARD  = PWM_BITS'(DUTY_HARD);
    localparam logic [PWM_BITS-1:0] D_PIVOT = PWM_BITS'(DUTY_PIVOT);

    localparam logic [TICK_W-1:0] PIVOT_LAST  = TICK_W'(PIVOT_TICKS - 1);
    localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_TICKS - 1);

    state_t              state;
    state_t              state_n;
    logic [TICK_W-1:0]   tick;
    logic                pivot_left;
    logic                dir_ok;
    logic                dir_stop;
    logic [PWM_BITS-1:0] tgt_l;
    logic [PWM_BITS-1:0] tgt_r;
    logic                rev_tgt_l;
    logic                rev_tgt_r;
    logic                pwm_l_raw;
    logic                pwm_r_raw;
    logic                rev_l_raw;
    logic                rev_r_raw;
    logic                active;

    // Tick count holds at its ceiling instead of wrapping.
    function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
        sat_inc = (v == {TICK_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign dir_ok   = dir_defined(DIR);
    assign dir_stop = (DIR == DIR_STOP);

    // State register, dwell counter (cleared on every state change), pivot side latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick       <= '0;
            pivot_left <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                tick <= '0;
            else
                tick <= sat_inc(tick);
            if ((state == ST_RUN) && (state_n == ST_PIVOT))
                pivot_left <= (DIR[3:2] == TURN_LEFT);
        end
    end

    // Next state; DIR is only consulted in RUN and HALT, enable low wins over all.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:   state_n = ST_RUN;
            ST_RUN: begin
                if (!dir_ok || dir_stop)
                    state_n = ST_HALT;
                else if (DIR[1:0] == GRADE_NINETY)
                    state_n = ST_PIVOT;
            end
            ST_PIVOT:  if (tick == PIVOT_LAST)  state_n = ST_SETTLE;
            ST_SETTLE: if (tick == SETTLE_LAST) state_n = ST_RUN;
            ST_HALT:   if (dir_ok && !dir_stop) state_n = ST_RUN;
            default:   state_n = ST_IDLE;
        endcase
        if (!enable)
            state_n = ST_IDLE;
    end

    // Per-cycle duty and reverse targets; pwm_gen samples them at the period wrap.
    always_comb begin
        tgt_l     = '0;
        tgt_r     = '0;
        rev_tgt_l = 1'b0;
        rev_tgt_r = 1'b0;
        unique case (state)
            ST_RUN: begin
                tgt_l = D_FULL;
                tgt_r = D_FULL;
                if (DIR[1:0] == GRADE_VEER) begin
                    if (DIR[3:2] == TURN_RIGHT) tgt_r = D_VEER;
                    if (DIR[3:2] == TURN_LEFT)  tgt_l = D_VEER;
                end else if (DIR[1:0] == GRADE_HARD) begin
                    if (DIR[3:2] == TURN_RIGHT) tgt_r = D_HARD;
                    if (DIR[3:2] == TURN_LEFT)  tgt_l = D_HARD;
                end
            end
            ST_PIVOT: begin
                tgt_l     = D_PIVOT;
                tgt_r     = D_PIVOT;
                rev_tgt_l = pivot_left;
                rev_tgt_r = !pivot_left;
            end
            ST_SETTLE: begin
                tgt_l = D_FULL;
                tgt_r = D_FULL;
            end
            default: ;
        endcase
    end

    pwm_gen #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP)
    ) u_pwm_left (
        .clk        (clk),
        .rst        (rst),
        .target     (tgt_l),
        .rev_target (rev_tgt_l),
        .pwm        (pwm_l_raw),
        .rev        (rev_l_raw)
    );

    pwm_gen #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP)
    ) u_pwm_right (
        .clk        (clk),
        .rst        (rst),
        .target     (tgt_r),
        .rev_target (rev_tgt_r),
        .pwm        (pwm_r_raw),
        .rev        (rev_r_raw)
    );

    // Motors are silenced immediately in IDLE and HALT, not at the next period.
    assign active    = (state == ST_RUN) || (state == ST_PIVOT) || (state == ST_SETTLE);
    assign left_pwm  = pwm_l_raw & active;
    assign right_pwm = pwm_r_raw & active;
    assign left_rev  = rev_l_raw & active;
    assign right_rev = rev_r_raw & active;
    assign busy      = (state == ST_PIVOT) || (state == ST_SETTLE);
    assign halted    = (state == ST_HALT);

endmodule
